// File: rtl/pair_serializer_pkg.sv
// Shared types and constants for the pair serializer.
// The state encoding is fixed at 2 bits. The unused code 2'b11 behaves as idle.
// Helper functions classify a state without duplicating decode in each file.
package pair_serializer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_W0   = 2'b01,
    S_W1   = 2'b10
  } ser_state_t;

  // True when the state is presenting a word. The unused code falls out as idle.
  function automatic logic state_presents(input ser_state_t s);
    return (s == S_W0) || (s == S_W1);
  endfunction

endpackage : pair_serializer_pkg

// File: rtl/pair_serializer_flopenr.sv
// Enabled data register with asynchronous active-high clear.
// Latency: q follows d one clock after en is sampled high.
// Backpressure: none; q holds its value whenever en is low.
module flopenr #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load on enable, clear immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : flopenr

// File: rtl/pair_serializer.sv
// Serializes an accepted (d0, d1) pair onto one valid/ready word channel, d0 first.
// Latency: first word is valid 1 cycle after accept; two-word pairs stream at 1 pair per 2 cycles.
// Backpressure: out_* hold steady while out_ready is low; in_ready reopens on the final beat.
module pair_serializer
  import pair_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_single,
  input  logic [WIDTH-1:0] in_d0,
  input  logic [WIDTH-1:0] in_d1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  ser_state_t       state_q;
  ser_state_t       state_d;
  logic             single_q;
  logic             single_d;
  logic [WIDTH-1:0] hold0_q;
  logic [WIDTH-1:0] hold1_q;

  logic             accept;
  logic             beat;

  // Handshake qualifiers. out_valid/out_last come only from registers, so the
  // only combinational input-to-output path is out_ready -> in_ready.
  assign beat   = out_valid && out_ready;
  assign accept = in_valid && in_ready;

  // Word holding registers: loaded only when a pair is accepted.
  flopenr #(.WIDTH(WIDTH)) u_hold0 (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .d     (in_d0),
    .q     (hold0_q)
  );

  flopenr #(.WIDTH(WIDTH)) u_hold1 (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .d     (in_d1),
    .q     (hold1_q)
  );

  // Single-word flag travels with the held pair.
  assign single_d = accept ? in_single : single_q;

  // State and mode flag registers; reset discards any partially sent pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      single_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      single_q <= single_d;
    end
  end

  // Next-state: advance only on a beat; a new pair taken on the final beat
  // restarts at S_W0 without passing through idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_W0: begin
        if (beat) begin
          if (!single_q) begin
            state_d = S_W1;
          end else if (accept) begin
            state_d = S_W0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_W1: begin
        if (beat) begin
          state_d = accept ? S_W0 : S_IDLE;
        end
      end
      default: begin
        // S_IDLE and the unused code both behave as idle.
        state_d = accept ? S_W0 : S_IDLE;
      end
    endcase
  end

  // Output decode: everything except in_ready is a function of registered state.
  always_comb begin
    out_valid = state_presents(state_q);
    busy      = state_presents(state_q);
    out_data  = '0;
    out_last  = 1'b0;
    unique case (state_q)
      S_W0: begin
        out_data = hold0_q;
        out_last = single_q;
      end
      S_W1: begin
        out_data = hold1_q;
        out_last = 1'b1;
      end
      default: begin
        out_data = '0;
        out_last = 1'b0;
      end
    endcase
    in_ready = !state_presents(state_q) || (out_valid && out_ready && out_last);
  end

endmodule : pair_serializer

// File: doc/pair_serializer.md
# pair_serializer

Transmit-side counterpart of the two-word capture register in the multicycle ARM datapath. Accepts a pair of words (d0, d1) in one handshake and emits them one word per beat on a single WIDTH-bit valid/ready channel, d0 first. It feeds two-word transfers, such as register-pair stores, into the single-ported memory path. An optional single-word mode sends only d0.

## Interface
- WIDTH, 32, width of each data word.

- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  producer offers a pair.
- in_ready  output  1  serializer accepts the pair this cycle.
- in_single  input  1  sampled with the pair; 1 = send d0 only.
- in_d0  input  WIDTH  first word.
- in_d1  input  WIDTH  second word; ignored when in_single=1.
- out_valid  output  1  out_data holds a word to send.
- out_ready  input  1  consumer takes the word this cycle.
- out_data  output  WIDTH  current word.
- out_last  output  1  current word is the final word of the pair.
- busy  output  1  a pair is held (state != S_IDLE).

## Operation
- Three states:
  - S_IDLE: nothing held.
  - S_W0: d0 is presented.
  - S_W1: d1 is presented.
- Registers: hold0, hold1 (WIDTH each), single_q, state.
- Accept occurs when in_valid && in_ready. On accept:
  - hold0 <= in_d0, hold1 <= in_d1, single_q <= in_single.
  - state <= S_W0.
- in_ready = (state==S_IDLE) || (out_valid && out_ready && out_last).
  - A new pair can be accepted in the same cycle the final word of the previous pair is taken.
- out_valid = (state==S_W0) || (state==S_W1).
- out_data: hold0 in S_W0, hold1 in S_W1, 0 in S_IDLE.
- out_last = (state==S_W1) || (state==S_W0 && single_q).
- Transitions on a beat (out_valid && out_ready):
  - S_W0, !single_q -> S_W1.
  - S_W0, single_q -> S_W0 if a simultaneous accept occurs, else S_IDLE.
  - S_W1 -> S_W0 if a simultaneous accept occurs, else S_IDLE.
- Without a beat, state and hold registers are unchanged.
- Backpressure: while out_valid && !out_ready, out_data and out_last stay stable. out_valid is never withdrawn before the beat.
- Hold registers load only on accept. Inputs are ignored in every other cycle.
- Reset, including mid-transfer: state=S_IDLE, hold0=hold1=0, single_q=0. Any partially sent pair is discarded, with no further beats.
- Reset values of outputs:
  - in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.

## Timing
- Latency from accept to first out_valid: 1 cycle (registered state).
- Two-word pair with out_ready held high: beats in cycles T+1 and T+2. in_ready is high in cycle T+2, so the next pair can be accepted there.
- Sustained throughput:
  - one pair per 2 cycles in two-word mode;
  - one pair per cycle in single mode.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to out_*.
- All outputs except in_ready are pure functions of registered state.

## Structure
- Shared package holds typedef ser_state_t, 2 bits:
  - S_IDLE=2'b00, S_W0=2'b01, S_W1=2'b10. 2'b11 is unused and decodes to S_IDLE behaviour.
- One sub-module: flopenr (WIDTH param, asynchronous active-high reset, enable), used for hold0 and hold1 with enable = accept.
- FSM and output decode live in pair_serializer itself.

## Test plan
- Reset:
  - Assert reset with random inputs.
  - Required: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
  - Deassert reset, keep in_valid=0 for 5 cycles. Required: outputs unchanged.
- Basic pair:
  - Accept d0=0x11111111, d1=0x22222222 with out_ready=1.
  - Required: next cycle out_data=0x11111111, last=0; following cycle out_data=0x22222222, last=1; then out_valid=0.
- Backpressure:
  - Same pair, out_ready=0 for 3 cycles in S_W0.
  - Required: out_data stays 0x11111111, out_valid stays 1, in_ready=0.
  - Drop inputs to random values. Required: output still 0x11111111.
  - Release out_ready. Required: d1 follows.
- Single mode:
  - Accept in_single=1, d0=0xDEADBEEF, d1=0xFFFFFFFF.
  - Required: exactly one beat, data=0xDEADBEEF with out_last=1; 0xFFFFFFFF never appears.
- Back-to-back:
  - Hold in_valid high with out_ready=1 for pairs (0xA0,0xA1), (0xB0,0xB1), (0xC0,0xC1).
  - Required: contiguous beat stream A0,A1,B0,B1,C0,C1 over 6 consecutive cycles; out_last on A1, B1, C1.
- Reset mid-operation:
  - Assert reset while in S_W1 with out_ready=0.
  - Required: immediate out_valid=0, busy=0.
  - After release, accept a new pair 0x5/0x6. Required: 0x5 then 0x6 only, no stale word.
